// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx: pairs left/right PCM samples into stereo frames, buffers them
// in a small FIFO and plays them out as a Philips-I2S master (bclk, lrclk,
// sdata all derived from clk and driven straight from flops).
//
// Input handshake: stb_in is a one-cycle strobe with no back-pressure. din
// and in_right are valid only in the cycle stb_in is high. A sample that
// cannot be used is dropped and flagged (sync_err / overflow), never stalled.
module pcm_i2s_tx #(
  parameter int DEPTH    = 4,
  parameter int BCLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stb_in,
  input  logic                       in_right,
  input  logic [15:0]                din,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  output logic                       underrun,
  output logic                       sync_err,
  output logic                       i2s_bclk,
  output logic                       i2s_lrclk,
  output logic                       i2s_sdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  // bit-clock generation
  logic [DW-1:0] div_q;
  logic          bclk_q;
  logic          div_tick;
  logic          fall_tick;

  // serialiser
  logic [4:0]    slot_q;
  logic [4:0]    slot_nxt;
  logic [31:0]   shift_q;
  logic [31:0]   shift_nxt;
  logic          lrclk_q;
  logic          sdata_q;

  // pairing
  logic [15:0]   hold_q;
  logic          hold_valid_q;

  // FIFO
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_nxt;
  logic          full_q;
  logic          fifo_empty;
  logic          pop_req;
  logic          pop;
  logic          push_req;
  logic          push;

  // status pulses
  logic          overflow_q;
  logic          underrun_q;
  logic          sync_err_q;

  // Decode the divider terminal count, the bclk falling toggle and the
  // push/pop decisions for this cycle.
  always_comb begin
    div_tick   = 1'b0;
    fall_tick  = 1'b0;
    slot_nxt   = slot_q + 5'd1;
    fifo_empty = 1'b0;
    pop_req    = 1'b0;
    pop        = 1'b0;
    push_req   = 1'b0;
    push       = 1'b0;

    div_tick   = (div_q == DW'(BCLK_DIV - 1));
    fall_tick  = div_tick & bclk_q;
    fifo_empty = (level_q == '0);
    // The frame is loaded on the falling edge that starts slot 1, which
    // yields the one-bit I2S delay behind the lrclk transition.
    pop_req    = fall_tick & (slot_nxt == 5'd1);
    pop        = pop_req & ~fifo_empty;
    push_req   = stb_in & in_right & hold_valid_q;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push       = push_req & ((level_q != LW'(DEPTH)) | pop);
  end

  // Next shift-register contents and next FIFO occupancy.
  always_comb begin
    shift_nxt = shift_q;
    level_nxt = level_q;

    if (pop_req) begin
      shift_nxt = pop ? mem[rd_ptr_q] : 32'd0;
    end else begin
      shift_nxt = {shift_q[30:0], 1'b0};
    end

    case ({push, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  // Divider and bit clock: bclk toggles every BCLK_DIV clk cycles, first
  // toggle after reset is rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (div_tick) begin
      div_q  <= '0;
      bclk_q <= ~bclk_q;
    end else begin
      div_q  <= div_q + DW'(1);
    end
  end

  // Serialiser: on every falling bclk toggle advance the slot, load or shift
  // the frame, and register the new line values alongside bclk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= 5'd0;
      shift_q <= 32'd0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
    end else if (fall_tick) begin
      slot_q  <= slot_nxt;
      shift_q <= shift_nxt;
      lrclk_q <= slot_nxt[4];
      sdata_q <= shift_nxt[31];
    end
  end

  // Left-sample hold register used to pair a left with the next right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= 16'd0;
      hold_valid_q <= 1'b0;
    end else if (stb_in) begin
      if (!in_right) begin
        hold_q       <= din;
        hold_valid_q <= 1'b1;
      end else begin
        // A right sample always consumes the hold, accepted or not.
        hold_valid_q <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {hold_q, din};
    end
  end

  // FIFO pointers, level and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == LW'(DEPTH));
    end
  end

  // One-cycle status pulses, registered in the cycle after their cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      overflow_q <= push_req & ~push;
      underrun_q <= pop_req & fifo_empty;
      sync_err_q <= stb_in & (in_right ? ~hold_valid_q : hold_valid_q);
    end
  end

  assign level     = level_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign underrun  = underrun_q;
  assign sync_err  = sync_err_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx with DEPTH=4, BCLK_DIV=2 (bclk period 4 clk, frame
// 128 clk). A cycle counter n (edges since reset release) drives an
// independent model of bclk/lrclk; an I2S receiver rebuilds frames and
// checks them against an expected queue.
module tb_pcm_i2s_tx;

  localparam int DEPTH    = 4;
  localparam int BCLK_DIV = 2;

  logic        clk;
  logic        rst_n;
  logic        stb_in;
  logic        in_right;
  logic [15:0] din;
  logic [2:0]  level;
  logic        full;
  logic        overflow;
  logic        underrun;
  logic        sync_err;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;

  int comps;
  int fails;
  int n;
  int rx_count;
  int bits;
  logic        prev_lr;
  logic        prev_bclk;
  logic [31:0] rx;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        stb;
    logic        rgt;
    logic [15:0] din;
    logic        exp_sync;
    logic        exp_ovf;
    logic [2:0]  exp_level;
    logic        exp_full;
    logic        push;
    logic [31:0] frame;
  } vec_t;

  vec_t vt [14];

  pcm_i2s_tx #(.DEPTH(DEPTH), .BCLK_DIV(BCLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stb_in    (stb_in),
    .in_right  (in_right),
    .din       (din),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .underrun  (underrun),
    .sync_err  (sync_err),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata)
  );

  // clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got %h expected %h", nm, n, act, exp);
    end
  endtask

  // Line model and I2S receiver, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      bits      = 0;
      prev_lr   = 1'b0;
      prev_bclk = 1'b0;
      rx        = 32'd0;
    end else begin
      chk("bclk", i2s_bclk, (n >> 1) & 1);
      chk("lrclk", i2s_lrclk, ((n >> 2) & 31) >= 16);
      if (i2s_bclk && !prev_bclk) begin
        rx = {rx[30:0], i2s_sdata};
        bits++;
        if (prev_lr && !i2s_lrclk) begin
          if (bits >= 32 && rx != 32'd0) begin
            rx_count++;
            if (exp_q.size() == 0) begin
              chk("frame_unexpected", rx, 32'd0);
            end else begin
              chk("frame", rx, exp_q.pop_front());
            end
          end
          bits = 0;
        end
        prev_lr = i2s_lrclk;
      end
      prev_bclk = i2s_bclk;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] d);
    stb_in   = s;
    in_right = r;
    din      = d;
    tick();
    stb_in   = 1'b0;
    in_right = 1'b0;
    din      = 16'd0;
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((n % 128) != ph && k < 300);
    chk("wait_phase", n % 128, ph);
  endtask

  initial begin
    comps    = 0;
    fails    = 0;
    rx_count = 0;
    rst_n    = 1'b0;
    stb_in   = 1'b0;
    in_right = 1'b0;
    din      = 16'd0;

    //                 stb   rgt   din       sync  ovf   lvl   full  push  frame
    vt[0]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0003_0004};
    vt[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h1111_2222};
    vt[7]  = '{1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 32'h3333_4444};
    vt[9]  = '{1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b1, 16'h6666, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 32'h5555_6666};
    vt[11] = '{1'b1, 1'b0, 16'h7777, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h0};
    vt[12] = '{1'b1, 1'b1, 16'h0888, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 32'h0};
    vt[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h0};

    // reset, then idle: sdata low, one underrun per frame at slot 1
    repeat (3) tick();
    chk("reset_outputs",
        {level, full, overflow, underrun, sync_err, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 270; i++) begin
      tick();
      chk("underrun_idle", underrun, (n % 128) == 4);
      chk("sdata_idle", i2s_sdata, 1'b0);
    end

    // single frame L=8001 R=7FFE ahead of the next slot-1 edge (n=388)
    drive(1'b1, 1'b0, 16'h8001);
    chk("b_level_after_l", level, 3'd0);
    drive(1'b1, 1'b1, 16'h7FFE);
    chk("b_level_after_r", level, 3'd1);
    chk("b_sync", sync_err, 1'b0);
    exp_q.push_back(32'h8001_7FFE);
    wait_phase(4);
    chk("b_level_after_pop", level, 3'd0);
    chk("b_no_underrun", underrun, 1'b0);

    // pairing, fill to full and overflow, clear of any pop
    wait_phase(10);
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].stb, vt[i].rgt, vt[i].din);
      chk("vec_sync_err", sync_err, vt[i].exp_sync);
      chk("vec_overflow", overflow, vt[i].exp_ovf);
      chk("vec_level", level, vt[i].exp_level);
      chk("vec_full", full, vt[i].exp_full);
      if (vt[i].push) exp_q.push_back(vt[i].frame);
    end

    // push landing on the pop edge while full: accepted, level holds at 4
    wait_phase(2);
    drive(1'b1, 1'b0, 16'hAAAA);
    drive(1'b1, 1'b1, 16'h5555);
    exp_q.push_back(32'hAAAA_5555);
    chk("d_overflow", overflow, 1'b0);
    chk("d_level", level, 3'd4);
    chk("d_full", full, 1'b1);
    chk("d_underrun", underrun, 1'b0);
    tick();
    chk("d_overflow_next", overflow, 1'b0);

    // drain to level 2, then reset at slot 9
    wait_phase(4);
    chk("e_level3", level, 3'd3);
    wait_phase(4);
    chk("e_level2", level, 3'd2);
    repeat (32) tick();
    chk("e_level_slot9", level, 3'd2);
    chk("e_rx_count", rx_count, 3);
    chk("e_pending", exp_q.size(), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("e_reset_outputs",
        {level, full, overflow, underrun, sync_err, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("e_level_after_reset", level, 3'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("e_underrun_first", underrun, n == 4);
    end
    repeat (140) tick();
    chk("final_rx_count", rx_count, 3);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule

// File: doc/pcm_i2s_tx.md
Name: pcm_i2s_tx

Overview:
Downstream consumer of the audio comb/decimation filter. Takes one 16-bit signed PCM result per channel, pairs left and right into stereo frames, and buffers the frames in a small FIFO. Serialises the frames as a Philips-I2S master: bclk, lrclk and sdata, all generated from clk. Reports overflow, underrun and channel-order errors to the control logic.

Parameters:
DEPTH, 4, FIFO depth in stereo frames; must be a power of 2 and at least 2
BCLK_DIV, 4, clk cycles per bclk half-period; must be at least 1

Ports:
clk  in  1  system clock; every register is clocked on its rising edge
rst_n  in  1  asynchronous, active-low reset
stb_in  in  1  one-cycle strobe: din holds a valid sample
in_right  in  1  channel of din (0 = left, 1 = right); sampled with stb_in
din  in  16  signed PCM sample
level  out  $clog2(DEPTH)+1  number of frames in the FIFO
full  out  1  high when level equals DEPTH
overflow  out  1  one-cycle pulse: a completed frame was dropped
underrun  out  1  one-cycle pulse: a frame slot was sent with the FIFO empty
sync_err  out  1  one-cycle pulse: channel-order violation
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select (0 = left)
i2s_sdata  out  1  serial data, MSB first

Behaviour:
- Reset (async, rst_n=0): all outputs 0. FIFO empty, hold register empty, divider=0, slot=0, shift register=0. Reset asserted mid-frame aborts the frame immediately and discards all buffered data.
- Pairing:
  - stb_in with in_right=0 loads din into the left hold register and sets hold_valid.
  - If hold_valid was already set, the old left sample is overwritten and sync_err pulses.
  - stb_in with in_right=1 and hold_valid=1 pushes the frame {left,din} (32 bits, left in [31:16]) and clears hold_valid.
  - stb_in with in_right=1 and hold_valid=0 drops din and pulses sync_err.
- Push acceptance:
  - A push is accepted when level<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the frame is dropped, overflow pulses in the cycle after the stb_in, and level is unchanged.
- Push and pop in the same cycle leave level unchanged. Pointers wrap modulo DEPTH. full and level are registered and update in the cycle after the push or pop.
- Bit clock:
  - The divider counts 0..BCLK_DIV-1. When it is at BCLK_DIV-1, the divider returns to 0 and i2s_bclk toggles.
  - The bclk period is 2*BCLK_DIV clk cycles. The first toggle after reset is rising.
- Slot counter: 5 bits, 0..31. It increments (wrapping 31 to 0) on every falling toggle of i2s_bclk. A frame spans 64*BCLK_DIV clk cycles.
- On each falling toggle (registered together with i2s_bclk going low):
  - Slot becomes 1: pop the FIFO head into the 32-bit shift register. If the FIFO is empty, load 0 and pulse underrun.
  - Slot becomes any other value: shift the register left by one, filling with 0.
  - i2s_sdata = shift register bit 31, taken after the load or shift.
  - i2s_lrclk = 1 for slots 16..31 and 0 for slots 0..15.
- Resulting line mapping: left MSB in slot 1, left LSB in slot 16, right MSB in slot 17, right LSB in slot 0 of the following frame. This gives standard I2S one-bit delay. The receiver samples on the bclk rising edge.
- i2s_bclk, i2s_lrclk and i2s_sdata are direct register outputs and glitch-free.
- Frames leave in FIFO order, with no reordering and no duplication.

Test Plan:
- Reset, then no input, DEPTH=4, BCLK_DIV=2 -> bclk period 4 clk, lrclk period 128 clk. sdata stays 0. underrun pulses once per frame, at the clk where the slot becomes 1.
- Push L=0x8001 and R=0x7FFE before the first slot-1 falling edge -> slots 1..16 carry 1000000000000001, slots 17..31 and next slot 0 carry 0111111111111110. lrclk is 0 during left and 1 during right. level goes 0 to 1 to 0.
- Push 5 frames back-to-back with no pops, DEPTH=4 -> level=4 and full=1 after the 4th. The 5th frame is dropped with one overflow pulse. The output then plays frames 1..4 in order.
- Sequence R, L, L, R with values 1,2,3,4 -> sync_err pulses on the first R and on the second L. Exactly one frame {3,4} is pushed.
- Hold level=4; time the stb_in of a right sample to land in the same cycle as a pop -> push accepted, no overflow, level stays 4.
- Assert rst_n=0 mid-frame at slot 9 with level=2 -> all outputs 0 at once. After release, level=0 and the first frame underruns.
